decode_ctl: RTL and testbench

Sequencing controller for the decode-stage uop queue. It sits between fetch (FE1) and the uop queue that feeds rename. It tracks queue occupancy, applies backpressure to fetch, and gates pushes. It sequences two events that interrupt decode: branch-mispredict flush from retire (RB1) and the EBREAK halt/drain. It owns no payload, only control.

---
 rtl/decode_ctl.sv | 83 ++++++++
 tb/tb_decode_ctl.sv | 118 +++++++++++
 2 files changed

// File: rtl/decode_ctl.sv
// decode_ctl: occupancy, backpressure and flush/halt sequencing for the decode uop queue
module decode_ctl #(
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_fe1,
  input  logic                       is_ebreak_de0,
  input  logic                       uopq_pop_de1,
  input  logic                       br_mispred_rb1,
  input  logic                       resume_dbg,
  output logic                       uopq_push_de0,
  output logic                       uopq_flush_de0,
  output logic                       fe_stall_de0,
  output logic [$clog2(DEPTH+1)-1:0] uopq_count,
  output logic                       halted
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_CYCLES);
  typedef enum logic [1:0] {RUN, FLUSH, HALT_DRAIN, HALTED} state_e;
  state_e          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic            space;
  always_comb begin
    space          = (count_q < DEPTH_C) | uopq_pop_de1;
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    uopq_push_de0  = 1'b0;
    uopq_flush_de0 = 1'b0;
    fe_stall_de0   = 1'b0;
    case (state_q)
      RUN: begin
        uopq_push_de0 = valid_fe1 & space;
        fe_stall_de0  = valid_fe1 & ~space;
        state_d       = (uopq_push_de0 & is_ebreak_de0) ? HALT_DRAIN : RUN;
      end
      FLUSH: begin
        fcnt_d  = fcnt_q - FW'(1);
        state_d = (fcnt_q == FW'(1)) ? RUN : FLUSH;
      end
      HALT_DRAIN: begin
        fe_stall_de0 = 1'b1;
        state_d = (count_q == '0 || (count_q == CW'(1) && uopq_pop_de1)) ? HALTED : HALT_DRAIN;
      end
      HALTED: begin
        fe_stall_de0 = 1'b1;
        state_d      = resume_dbg ? RUN : HALTED;
      end
    endcase
    // a mispredict overrides whatever the current state wanted
    if (br_mispred_rb1) begin
      uopq_push_de0  = 1'b0;
      uopq_flush_de0 = 1'b1;
      state_d        = FLUSH;
      fcnt_d         = FLUSH_C;
    end
    if (reset) begin
      uopq_push_de0  = 1'b0;
      uopq_flush_de0 = 1'b0;
      fe_stall_de0   = 1'b0;
    end
    count_d = uopq_flush_de0 ? '0 : count_q + CW'(uopq_push_de0) - CW'(uopq_pop_de1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      count_q <= count_d;
    end
  end
  assign uopq_count = count_q;
  assign halted     = (state_q == HALTED);
  assert property (@(posedge clk) disable iff (reset)
    !(uopq_pop_de1 && count_q == '0) && count_q <= DEPTH_C);
endmodule

// File: tb/tb_decode_ctl.sv
// tb_decode_ctl: directed scenarios plus random traffic against a behavioural model
module tb_decode_ctl;
  localparam int DEPTH = 2;
  localparam int FC    = 2;
  logic clk = 1'b0;
  logic reset, valid_fe1, is_ebreak_de0, uopq_pop_de1, br_mispred_rb1, resume_dbg;
  logic uopq_push_de0, uopq_flush_de0, fe_stall_de0, halted;
  logic [$clog2(DEPTH+1)-1:0] uopq_count;
  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int m_mode = 0;
  int m_left = 0;
  decode_ctl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .valid_fe1(valid_fe1), .is_ebreak_de0(is_ebreak_de0),
    .uopq_pop_de1(uopq_pop_de1), .br_mispred_rb1(br_mispred_rb1), .resume_dbg(resume_dbg),
    .uopq_push_de0(uopq_push_de0), .uopq_flush_de0(uopq_flush_de0),
    .fe_stall_de0(fe_stall_de0), .uopq_count(uopq_count), .halted(halted));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  // mode: 0 run, 1 flush, 2 halt-drain, 3 halted
  task automatic step(input logic v, input logic eb, input logic pop, input logic mis,
                      input logic res, input logic rst);
    bit space, e_push, e_flush, e_stall;
    valid_fe1 = v; is_ebreak_de0 = eb; uopq_pop_de1 = pop;
    br_mispred_rb1 = mis; resume_dbg = res; reset = rst;
    space   = (m_cnt < DEPTH) || pop;
    e_flush = !rst && mis;
    e_push  = !rst && !mis && m_mode == 0 && v && space;
    e_stall = !rst && ((m_mode == 0 && v && !space) || m_mode >= 2);
    #1;
    chk("push", int'(uopq_push_de0), int'(e_push));
    chk("flush", int'(uopq_flush_de0), int'(e_flush));
    chk("stall", int'(fe_stall_de0), int'(e_stall));
    chk("count", int'(uopq_count), m_cnt);
    chk("halted", int'(halted), int'(m_mode == 3));
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_left = 0;
    end else if (mis) begin
      m_mode = 1; m_left = FC; m_cnt = 0;
    end else begin
      if (m_mode == 0 && e_push && eb) m_mode = 2;
      else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end else if (m_mode == 2 && (m_cnt == 0 || (m_cnt == 1 && pop))) m_mode = 3;
      else if (m_mode == 3 && res) m_mode = 0;
      m_cnt = m_cnt + int'(e_push) - int'(pop);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    bit v, eb, pop, mis, res, rst;
    @(negedge clk);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    // back-to-back fill, no pops
    repeat (4) step(1, 0, 0, 0, 0, 0);
    chk("fill_count", int'(uopq_count), 2);
    // full with simultaneous pop
    step(1, 0, 1, 0, 0, 0);
    chk("full_pop_count", int'(uopq_count), 2);
    // mispredict mid-stream, first push at T+3
    step(1, 0, 0, 1, 0, 0);
    chk("mis_count", int'(uopq_count), 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("mis_first_push", int'(uopq_count), 1);
    // back-to-back mispredicts delay the first push to T+4
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("mis2_first_push", int'(uopq_count), 1);
    // EBREAK drain from count=1
    step(1, 1, 0, 0, 0, 0);
    chk("eb_count", int'(uopq_count), 2);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("drain_halted", int'(halted), 1);
    step(0, 1, 0, 0, 1, 0);
    chk("resume_halted", int'(halted), 0);
    // mispredict while halted
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("halt2", int'(halted), 1);
    step(0, 0, 0, 1, 0, 0);
    chk("mis_halt_drop", int'(halted), 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // reset during HALT_DRAIN with count=2
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("pre_rst_count", int'(uopq_count), 2);
    step(1, 0, 0, 0, 0, 1);
    chk("post_rst_count", int'(uopq_count), 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) < 2);
      mis = ($urandom_range(99) < 6);
      eb  = ($urandom_range(99) < 15);
      res = ($urandom_range(99) < 20);
      v   = ($urandom_range(99) < 70);
      pop = (m_cnt > 0) && ($urandom_range(99) < 50);
      step(v, eb, pop, mis, res, rst);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
